// File: rtl/time_setting_ctrl.sv
//==============================================================================
// Module      : time_setting_ctrl
// Description : Wall-clock settings editor. Turns debounced mode/inc/dec
//               button levels into an edit sequence over hours then minutes,
//               presents the edited values to the display-select stage and
//               issues a one-cycle load pulse when the edit is committed.
//               Optional feature macro: AUTO_REPEAT_EN (hold-to-repeat on
//               inc/dec; when undefined, only button edges step a field).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module time_setting_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned HOLD_CYCLES    = 25_000_000,
  parameter int unsigned REPEAT_CYCLES  = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [6:0] minutes,
  input  logic [5:0] hours,
  output logic [6:0] minutes_settings,
  output logic [5:0] hours_settings,
  output logic       settings_signal,
  output logic       edit_field,
  output logic       load_time
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SET_HOURS   = 2'd1,
    SET_MINUTES = 2'd2,
    COMMIT      = 2'd3
  } state_t;

  // Timeout counter only ever needs to hold 0 .. TIMEOUT_CYCLES-1.
  localparam int c_tw = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_tw-1:0] c_tmo_last = c_tw'(TIMEOUT_CYCLES - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_prev_mode;
  logic            r_prev_inc;
  logic            r_prev_dec;
  logic [5:0]      r_hours_set;
  logic [6:0]      r_min_set;
  logic [5:0]      w_hours_nxt;
  logic [6:0]      w_min_nxt;
  logic [c_tw-1:0] r_tmo;

  logic w_pr_mode;
  logic w_pr_inc;
  logic w_pr_dec;
  logic w_inc_ev;
  logic w_dec_ev;
  logic w_step_up;
  logic w_step_dn;
  logic w_rep_fire;
  logic w_activity;
  logic w_tmo_hit;
  logic w_editing;

  assign w_pr_mode = btn_mode & ~r_prev_mode;
  assign w_pr_inc  = btn_inc  & ~r_prev_inc;
  assign w_pr_dec  = btn_dec  & ~r_prev_dec;
  assign w_editing = (r_state == SET_HOURS) || (r_state == SET_MINUTES);

`ifdef AUTO_REPEAT_EN
  // Repeat counter covers the longer of the hold and repeat intervals.
  localparam int unsigned c_rpt_max = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int c_rw = (c_rpt_max > 2) ? $clog2(c_rpt_max) : 1;
  localparam logic [c_rw-1:0] c_hold_last = c_rw'(HOLD_CYCLES - 1);
  localparam logic [c_rw-1:0] c_rep_last  = c_rw'(REPEAT_CYCLES - 1);

  logic            r_rpt_phase;
  logic [c_rw-1:0] r_rpt_cnt;
  logic            w_hold_one;

  // Exactly one of inc/dec held while a field is being edited.
  assign w_hold_one = (btn_inc ^ btn_dec) & w_editing;
  assign w_rep_fire = w_hold_one &
                      (r_rpt_phase ? (r_rpt_cnt == c_rep_last) : (r_rpt_cnt == c_hold_last));

  // Hold timer: first interval is the hold delay, then the repeat period.
  always_ff @(posedge clk) begin
    if (rst || !w_hold_one) begin
      r_rpt_phase <= 1'b0;
      r_rpt_cnt   <= '0;
    end else if (w_rep_fire) begin
      r_rpt_phase <= 1'b1;
      r_rpt_cnt   <= '0;
    end else begin
      r_rpt_cnt   <= r_rpt_cnt + 1'b1;
    end
  end

  assign w_inc_ev = w_pr_inc | (w_rep_fire & btn_inc);
  assign w_dec_ev = w_pr_dec | (w_rep_fire & btn_dec);
`else
  logic w_unused_cfg;

  // Hold/repeat timing is meaningless without auto-repeat.
  assign w_unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};
  assign w_rep_fire   = 1'b0;
  assign w_inc_ev     = w_pr_inc;
  assign w_dec_ev     = w_pr_dec;
`endif

  // Opposing steps in the same cycle cancel out.
  assign w_step_up  = w_inc_ev & ~w_dec_ev;
  assign w_step_dn  = w_dec_ev & ~w_inc_ev;
  assign w_activity = w_pr_mode | w_pr_inc | w_pr_dec | w_rep_fire;
  assign w_tmo_hit  = (r_tmo == c_tmo_last);

  // Previous button levels for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_mode <= 1'b0;
      r_prev_inc  <= 1'b0;
      r_prev_dec  <= 1'b0;
    end else begin
      r_prev_mode <= btn_mode;
      r_prev_inc  <= btn_inc;
      r_prev_dec  <= btn_dec;
    end
  end

  // Inactivity timer: held at zero outside editing, cleared by any activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= '0;
    end else if (!w_editing || w_activity) begin
      r_tmo <= '0;
    end else if (!w_tmo_hit) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  // Edit state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Edited field registers; values persist after leaving the editor.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hours_set <= '0;
      r_min_set   <= '0;
    end else begin
      r_hours_set <= w_hours_nxt;
      r_min_set   <= w_min_nxt;
    end
  end

  // Next state, field updates and state-decoded outputs; mode beats inc/dec.
  always_comb begin
    w_state_nxt     = r_state;
    w_hours_nxt     = r_hours_set;
    w_min_nxt       = r_min_set;
    settings_signal = 1'b0;
    edit_field      = 1'b0;
    load_time       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pr_mode) begin
          w_state_nxt = SET_HOURS;
          w_hours_nxt = (hours   > 6'd23) ? 6'd0 : hours;
          w_min_nxt   = (minutes > 7'd59) ? 7'd0 : minutes;
        end
      end
      SET_HOURS: begin
        settings_signal = 1'b1;
        if (w_pr_mode) begin
          w_state_nxt = SET_MINUTES;
        end else if (w_step_up) begin
          w_hours_nxt = (r_hours_set == 6'd23) ? 6'd0 : r_hours_set + 6'd1;
        end else if (w_step_dn) begin
          w_hours_nxt = (r_hours_set == 6'd0) ? 6'd23 : r_hours_set - 6'd1;
        end else if (!w_activity && w_tmo_hit) begin
          w_state_nxt = IDLE;
        end
      end
      SET_MINUTES: begin
        settings_signal = 1'b1;
        edit_field      = 1'b1;
        if (w_pr_mode) begin
          w_state_nxt = COMMIT;
        end else if (w_step_up) begin
          w_min_nxt = (r_min_set == 7'd59) ? 7'd0 : r_min_set + 7'd1;
        end else if (w_step_dn) begin
          w_min_nxt = (r_min_set == 7'd0) ? 7'd59 : r_min_set - 7'd1;
        end else if (!w_activity && w_tmo_hit) begin
          w_state_nxt = IDLE;
        end
      end
      COMMIT: begin
        settings_signal = 1'b1;
        load_time       = 1'b1;
        w_state_nxt     = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign hours_settings   = r_hours_set;
  assign minutes_settings = r_min_set;

endmodule

`default_nettype wire

// File: tb/tb_time_setting_ctrl.sv
//==============================================================================
// Module      : tb_time_setting_ctrl
// Description : Self-checking bench for time_setting_ctrl. A behavioural
//               model of the editor is compared against the DUT every cycle;
//               directed scenarios pin the model with literal expectations,
//               followed by randomized button/time stimulus.
//               Honours AUTO_REPEAT_EN for the hold-to-repeat scenario.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_time_setting_ctrl;

  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [6:0] minutes = '0;
  logic [5:0] hours = '0;
  logic [6:0] minutes_settings;
  logic [5:0] hours_settings;
  logic       settings_signal;
  logic       edit_field;
  logic       load_time;

  int n_vec = 0;
  int n_err = 0;
  int n_load = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 idle, 1 editing hours, 2 editing minutes, 3 committing.
  int m_st = 0;
  int m_h = 0;
  int m_m = 0;
  int m_q = 0;
  bit m_pm = 1'b0;
  bit m_pi = 1'b0;
  bit m_pd = 1'b0;

  always #5 clk = ~clk;

  time_setting_ctrl #(
    .TIMEOUT_CYCLES(T),
    .HOLD_CYCLES   (10),
    .REPEAT_CYCLES (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_mode        (btn_mode),
    .btn_inc         (btn_inc),
    .btn_dec         (btn_dec),
    .minutes         (minutes),
    .hours           (hours),
    .minutes_settings(minutes_settings),
    .hours_settings  (hours_settings),
    .settings_signal (settings_signal),
    .edit_field      (edit_field),
    .load_time       (load_time)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: applies the editing rules to the inputs seen at each edge.
  always @(posedge clk) begin : model
    int st, h, mi, q;
    bit pm, pi, pd;
    st = m_st; h = m_h; mi = m_m; q = m_q;
    pm = btn_mode && !m_pm;
    pi = btn_inc && !m_pi;
    pd = btn_dec && !m_pd;
    if (rst) begin
      st = 0; h = 0; mi = 0; q = 0;
    end else if (st == 0) begin
      if (pm) begin
        h  = (hours > 23) ? 0 : int'(hours);
        mi = (minutes > 59) ? 0 : int'(minutes);
        st = 1;
        q  = 0;
      end
    end else if (st == 3) begin
      st = 0;
    end else begin
      if (pm) begin
        st = st + 1;
        q  = 0;
      end else if (pi || pd) begin
        q = 0;
        if (pi != pd) begin
          if (st == 1) h = pi ? (h + 1) % 24 : (h + 23) % 24;
          else         mi = pi ? (mi + 1) % 60 : (mi + 59) % 60;
        end
      end else if (q == T - 1) begin
        st = 0;
      end else begin
        q = q + 1;
      end
    end
    m_st <= st; m_h <= h; m_m <= mi; m_q <= q;
    m_pm <= rst ? 1'b0 : btn_mode;
    m_pi <= rst ? 1'b0 : btn_inc;
    m_pd <= rst ? 1'b0 : btn_dec;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (load_time === 1'b1) n_load++;
    if (chk_en) begin
      check("model.hours",    int'(hours_settings),   m_h);
      check("model.minutes",  int'(minutes_settings), m_m);
      check("model.settings", int'(settings_signal),  int'(m_st != 0));
      check("model.field",    int'(edit_field),       int'(m_st == 2));
      check("model.load",     int'(load_time),        int'(m_st == 3));
    end
  end

  // Hold the given buttons for len cycles, then release; returns on a negedge.
  task automatic drive(input bit m, input bit i, input bit d, input int len);
    @(negedge clk);
    btn_mode = m; btn_inc = i; btn_dec = d;
    repeat (len) @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
  endtask

  task automatic press(input bit m, input bit i, input bit d);
    drive(m, i, d, 1);
    #1;
  endtask

  initial begin
    int lc;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset.settings", int'(settings_signal), 0);
    check("reset.hours", int'(hours_settings), 0);
    check("reset.minutes", int'(minutes_settings), 0);
    check("reset.load", int'(load_time), 0);
    check("reset.field", int'(edit_field), 0);

    // Capture 13:45 and run the full edit sequence.
    hours = 6'd13; minutes = 7'd45;
    press(1, 0, 0);
    check("enter.settings", int'(settings_signal), 1);
    check("enter.hours", int'(hours_settings), 13);
    check("enter.minutes", int'(minutes_settings), 45);
    check("enter.field", int'(edit_field), 0);
    press(0, 1, 0);
    press(0, 1, 0);
    check("inc2.hours", int'(hours_settings), 15);
    press(1, 0, 0);
    check("min.field", int'(edit_field), 1);
    repeat (5) press(0, 0, 1);
    check("dec5.minutes", int'(minutes_settings), 40);
    lc = n_load;
    press(1, 0, 0);
    check("commit.load", int'(load_time), 1);
    check("commit.settings", int'(settings_signal), 1);
    check("commit.hours", int'(hours_settings), 15);
    check("commit.minutes", int'(minutes_settings), 40);
    @(negedge clk); #1;
    check("post.load", int'(load_time), 0);
    check("post.settings", int'(settings_signal), 0);
    check("post.hours", int'(hours_settings), 15);
    check("post.minutes", int'(minutes_settings), 40);
    check("commit.pulses", n_load - lc, 1);

    // Wrap-around at the field limits.
    hours = 6'd23; minutes = 7'd59;
    press(1, 0, 0);
    press(0, 1, 0);
    check("wrap.h_inc", int'(hours_settings), 0);
    press(0, 0, 1);
    check("wrap.h_dec", int'(hours_settings), 23);
    press(1, 0, 0);
    press(0, 1, 0);
    check("wrap.m_inc", int'(minutes_settings), 0);
    check("wrap.no_carry", int'(hours_settings), 23);
    press(0, 0, 1);
    check("wrap.m_dec", int'(minutes_settings), 59);
    press(1, 0, 0);
    @(negedge clk); #1;

    // Simultaneous presses.
    hours = 6'd5; minutes = 7'd7;
    press(1, 0, 0);
    press(0, 1, 1);
    check("both.hours", int'(hours_settings), 5);
    press(1, 1, 0);
    check("mode_inc.field", int'(edit_field), 1);
    check("mode_inc.hours", int'(hours_settings), 5);

    // Reset in the middle of minutes editing.
    lc = n_load;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("rst_mid.settings", int'(settings_signal), 0);
    check("rst_mid.hours", int'(hours_settings), 0);
    check("rst_mid.minutes", int'(minutes_settings), 0);
    check("rst_mid.pulses", n_load - lc, 0);

    // Out-of-range capture is clamped per field.
    hours = 6'd30; minutes = 7'd33;
    press(1, 0, 0);
    check("clamp.hours", int'(hours_settings), 0);
    check("clamp.minutes", int'(minutes_settings), 33);

    // Inactivity timeout abandons the edit without a load pulse.
    lc = n_load;
    repeat (T - 1) @(negedge clk);
    #1;
    check("tmo.before", int'(settings_signal), 1);
    @(negedge clk); #1;
    check("tmo.after", int'(settings_signal), 0);
    check("tmo.pulses", n_load - lc, 0);

    // Randomized traffic.
    for (int it = 0; it < 600; it++) begin
      int r;
      r = int'($urandom_range(0, 39));
      if (r < 8) begin
        drive(1, 0, 0, int'($urandom_range(1, 3)));
      end else if (r < 17) begin
        drive(0, 1, 0, int'($urandom_range(1, 3)));
      end else if (r < 25) begin
        drive(0, 0, 1, int'($urandom_range(1, 3)));
      end else if (r < 27) begin
        drive(0, 1, 1, int'($urandom_range(1, 3)));
      end else if (r < 29) begin
        drive(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1);
      end else if (r < 31) begin
        repeat ($urandom_range(1, T + 20)) @(negedge clk);
      end else if (r < 38) begin
        @(negedge clk);
        hours   = 6'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 63 : 23));
        minutes = 7'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 127 : 59));
      end else if (r < 39) begin
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
      end else begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end
    @(negedge clk);

`ifdef AUTO_REPEAT_EN
    // Hold-to-repeat from minutes 10 for 30 cycles: edge + hold + 5 repeats.
    chk_en = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    hours = 6'd1; minutes = 7'd10;
    press(1, 0, 0);
    press(1, 0, 0);
    drive(0, 1, 0, 30);
    #1;
    check("repeat.minutes", int'(minutes_settings), 17);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
